// File: rtl/microstep_pkg.sv
// Shared encodings for microstep_sequencer: state codes, opcode classes and IR field positions.
package microstep_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_T0   = 3'd1,
        ST_T1   = 3'd2,
        ST_T2   = 3'd3,
        ST_T3   = 3'd4,
        ST_T4   = 3'd5,
        ST_T5   = 3'd6,
        ST_T6   = 3'd7
    } state_e;

    typedef enum logic [1:0] {
        CLS_ALU  = 2'd0,
        CLS_HILO = 2'd1,
        CLS_ILL  = 2'd2
    } opc_class_e;

    localparam int OPC_W   = 5;
    localparam int OPC_MSB = 31;
    localparam int RA_MSB  = 26;

    localparam logic [OPC_W-1:0] OPC_ALU_MIN = 5'h00;
    localparam logic [OPC_W-1:0] OPC_ALU_MAX = 5'h0B;
    localparam logic [OPC_W-1:0] OPC_MUL     = 5'h0E;
    localparam logic [OPC_W-1:0] OPC_DIV     = 5'h0F;

    // Unsigned offset compare keeps the ALU range check free of always-true terms.
    function automatic opc_class_e opc_class(input logic [OPC_W-1:0] opc);
        opc_class_e cls;
        if ((opc - OPC_ALU_MIN) <= (OPC_ALU_MAX - OPC_ALU_MIN)) begin
            cls = CLS_ALU;
        end else if ((opc == OPC_MUL) || (opc == OPC_DIV)) begin
            cls = CLS_HILO;
        end else begin
            cls = CLS_ILL;
        end
        return cls;
    endfunction

endpackage

// File: rtl/microstep_sequencer_onehot_decoder.sv
// onehot_decoder: binary index to N-bit one-hot enable; out-of-range indices give all zeros.
module onehot_decoder #(
    parameter int N = 16,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic         en,
    input  logic [W-1:0] idx,
    output logic [N-1:0] onehot
);

    // Combinational index decode.
    always_comb begin
        onehot = '0;
        for (int i = 0; i < N; i++) begin
            if (en && (idx == W'(i))) begin
                onehot[i] = 1'b1;
            end else begin
                onehot[i] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/microstep_sequencer.sv
// microstep_sequencer: fetch/execute control for reg-reg ALU and HI/LO instructions.
// Optional MICROSTEP_SINGLE_STEP_EN adds step_req; every non-IDLE state then waits for it.
module microstep_sequencer
    import microstep_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_REGS    = 16,
    parameter int OP_WIDTH    = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  clear,
    input  logic                  start,
    input  logic                  mem_rdy,
`ifdef MICROSTEP_SINGLE_STEP_EN
    input  logic                  step_req,
`endif
    input  logic [DATA_WIDTH-1:0] ir,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  PCout,
    output logic                  MARin,
    output logic                  IncPC,
    output logic                  PCin,
    output logic                  Read,
    output logic                  MDRin,
    output logic                  MDRout,
    output logic                  IRin,
    output logic                  Yin,
    output logic                  Zin_low,
    output logic                  Zin_high,
    output logic                  Zlowout,
    output logic                  Zhighout,
    output logic                  HIin,
    output logic                  LOin,
    output logic [NUM_REGS-1:0]   reg_out,
    output logic [NUM_REGS-1:0]   reg_in,
    output logic [OP_WIDTH-1:0]   operation
);

    localparam int REG_SEL_W = $clog2(NUM_REGS);
    localparam int CNT_W     = $clog2(MEM_TIMEOUT + 1);

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   first_t1_q, first_t1_d;
    logic [OPC_W-1:0]       opc_q, opc_d;
    logic [REG_SEL_W-1:0]   ra_q, ra_d;
    logic [REG_SEL_W-1:0]   rc_q, rc_d;
    logic [OP_WIDTH-1:0]    operation_q, operation_d;

    logic                   step_ok_s;
    logic                   hilo_s;
    logic [OPC_W-1:0]       ir_opc_s;
    logic [REG_SEL_W-1:0]   ir_ra_s, ir_rb_s, ir_rc_s;
    logic                   rout_en_s, rin_en_s;
    logic [REG_SEL_W-1:0]   rout_idx_s;
    logic                   unused_ir_s;

`ifdef MICROSTEP_SINGLE_STEP_EN
    assign step_ok_s = step_req;
`else
    assign step_ok_s = 1'b1;
`endif

    assign ir_opc_s    = ir[OPC_MSB -: OPC_W];
    assign ir_ra_s     = ir[RA_MSB -: REG_SEL_W];
    assign ir_rb_s     = ir[RA_MSB - REG_SEL_W -: REG_SEL_W];
    assign ir_rc_s     = ir[RA_MSB - 2 * REG_SEL_W -: REG_SEL_W];
    assign unused_ir_s = ^ir;
    assign hilo_s      = (opc_class(opc_q) == CLS_HILO);
    assign operation   = operation_q;

    // Next-state logic and Moore strobe decode; T1 err and T3 decode also look at mem_rdy / ir.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        first_t1_d  = 1'b0;
        opc_d       = opc_q;
        ra_d        = ra_q;
        rc_d        = rc_q;
        operation_d = operation_q;
        busy = 1'b0; done = 1'b0; err = 1'b0;
        PCout = 1'b0; MARin = 1'b0; IncPC = 1'b0; PCin = 1'b0; Read = 1'b0;
        MDRin = 1'b0; MDRout = 1'b0; IRin = 1'b0; Yin = 1'b0;
        Zin_low = 1'b0; Zin_high = 1'b0; Zlowout = 1'b0; Zhighout = 1'b0;
        HIin = 1'b0; LOin = 1'b0;
        rout_en_s  = 1'b0;
        rout_idx_s = rc_q;
        rin_en_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_T0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_T0: begin
                busy = 1'b1; PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin_low = 1'b1;
                cnt_d      = '0;
                first_t1_d = step_ok_s;
                if (step_ok_s) begin
                    state_d = ST_T1;
                end else begin
                    state_d = ST_T0;
                end
            end
            ST_T1: begin
                busy = 1'b1; Read = 1'b1; MDRin = 1'b1;
                PCin = first_t1_q; Zlowout = first_t1_q;
                // Waiting on step_req freezes both the timeout count and the first-cycle flag.
                if (!step_ok_s) begin
                    first_t1_d = first_t1_q;
                end else if (mem_rdy) begin
                    state_d = ST_T2;
                end else if (cnt_q == CNT_W'(MEM_TIMEOUT - 1)) begin
                    err     = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_T2: begin
                busy = 1'b1; MDRout = 1'b1; IRin = 1'b1;
                if (step_ok_s) begin
                    state_d = ST_T3;
                end else begin
                    state_d = ST_T2;
                end
            end
            ST_T3: begin
                busy = 1'b1;
                case (opc_class(ir_opc_s))
                    CLS_ALU, CLS_HILO: begin
                        Yin        = 1'b1;
                        rout_en_s  = 1'b1;
                        rout_idx_s = ir_rb_s;
                        if (step_ok_s) begin
                            opc_d       = ir_opc_s;
                            ra_d        = ir_ra_s;
                            rc_d        = ir_rc_s;
                            operation_d = OP_WIDTH'(ir_opc_s);
                            state_d     = ST_T4;
                        end else begin
                            state_d = ST_T3;
                        end
                    end
                    default: begin
                        err = step_ok_s;
                        if (step_ok_s) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_T3;
                        end
                    end
                endcase
            end
            ST_T4: begin
                busy = 1'b1; Zin_low = 1'b1; Zin_high = hilo_s;
                rout_en_s = 1'b1;
                if (step_ok_s) begin
                    state_d = ST_T5;
                end else begin
                    state_d = ST_T4;
                end
            end
            ST_T5: begin
                busy = 1'b1; Zlowout = 1'b1;
                if (hilo_s) begin
                    LOin = 1'b1;
                    if (step_ok_s) begin
                        state_d = ST_T6;
                    end else begin
                        state_d = ST_T5;
                    end
                end else begin
                    rin_en_s = 1'b1;
                    done     = step_ok_s;
                    if (step_ok_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_T5;
                    end
                end
            end
            ST_T6: begin
                busy = 1'b1; Zhighout = 1'b1; HIin = 1'b1;
                done = step_ok_s;
                if (step_ok_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_T6;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer state and latched instruction fields, cleared synchronously.
    always_ff @(posedge clk) begin
        if (clear) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            first_t1_q  <= 1'b0;
            opc_q       <= '0;
            ra_q        <= '0;
            rc_q        <= '0;
            operation_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            first_t1_q  <= first_t1_d;
            opc_q       <= opc_d;
            ra_q        <= ra_d;
            rc_q        <= rc_d;
            operation_q <= operation_d;
        end
    end

    onehot_decoder #(.N(NUM_REGS), .W(REG_SEL_W)) u_reg_out_dec (
        .en     (rout_en_s),
        .idx    (rout_idx_s),
        .onehot (reg_out)
    );

    onehot_decoder #(.N(NUM_REGS), .W(REG_SEL_W)) u_reg_in_dec (
        .en     (rin_en_s),
        .idx    (ra_q),
        .onehot (reg_in)
    );

endmodule

// File: tb/tb_microstep_sequencer.sv
// Scoreboard bench for microstep_sequencer: directed test-plan cases plus randomized instructions.
module tb_microstep_sequencer;

    localparam int TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        clear, start, mem_rdy;
    logic [31:0] ir;
    logic        busy, done, err;
    logic        PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin, Yin;
    logic        Zin_low, Zin_high, Zlowout, Zhighout, HIin, LOin;
    logic [15:0] reg_out, reg_in;
    logic [3:0]  operation;

    microstep_sequencer dut (
        .clk(clk), .clear(clear), .start(start), .mem_rdy(mem_rdy), .ir(ir),
        .busy(busy), .done(done), .err(err),
        .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .PCin(PCin), .Read(Read),
        .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin),
        .Zin_low(Zin_low), .Zin_high(Zin_high), .Zlowout(Zlowout), .Zhighout(Zhighout),
        .HIin(HIin), .LOin(LOin), .reg_out(reg_out), .reg_in(reg_in), .operation(operation)
    );

    always #5 clk = ~clk;

    logic [49:0] strobes;
    assign strobes = {busy, done, err, PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin,
                      Yin, Zin_low, Zin_high, Zlowout, Zhighout, HIin, LOin, reg_out, reg_in};

    typedef struct {
        bit          is_err;
        int          lat;
        int          reads;
        int          pcins;
        logic [15:0] rout_t3;
        logic [15:0] rout_t4;
        logic [15:0] rin_or;
        int          hi;
        int          lo;
        int          zh;
        logic [3:0]  op;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [3:0]  model_op = 4'd0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: instruction outcome from the opcode class, field values and memory wait.
    function automatic exp_t model(input logic [31:0] irv, input int w, input bit never);
        exp_t        e;
        logic [4:0]  opc;
        opc = irv[31:27];
        e.is_err = 1'b0; e.pcins = 1; e.rout_t3 = 16'd0; e.rout_t4 = 16'd0;
        e.rin_or = 16'd0; e.hi = 0; e.lo = 0; e.zh = 0; e.op = model_op;
        if (never) begin
            e.is_err = 1'b1; e.lat = 1 + TIMEOUT; e.reads = TIMEOUT;
            return e;
        end
        e.reads = w + 1;
        if (opc <= 5'd11 || opc == 5'd14 || opc == 5'd15) begin
            e.rout_t3 = 16'd1 << irv[22:19];
            e.rout_t4 = 16'd1 << irv[18:15];
            e.op      = opc[3:0];
            if (opc <= 5'd11) begin
                e.lat = 6 + w; e.rin_or = 16'd1 << irv[26:23];
            end else begin
                e.lat = 7 + w; e.hi = 1; e.lo = 1; e.zh = 1;
            end
        end else begin
            e.is_err = 1'b1; e.lat = 4 + w;
        end
        return e;
    endfunction

    // Monitor accumulators for the instruction in flight.
    int          m_lat, m_reads, m_pcins, m_hi, m_lo, m_zh;
    logic [15:0] m_rin;

    task automatic acc_reset();
        m_lat = 0; m_reads = 0; m_pcins = 0; m_hi = 0; m_lo = 0; m_zh = 0; m_rin = 16'd0;
    endtask

    initial acc_reset();

    always @(negedge clk) begin
        if (clear) begin
            acc_reset();
        end else if (!busy) begin
            chk("idle_zero", 64'(strobes), 64'd0);
        end else begin
            exp_t e;
            chk("out_in_exclusive", 64'((|reg_out) && (|reg_in)), 64'd0);
            m_lat++; m_reads += int'(Read); m_pcins += int'(PCin);
            m_hi += int'(HIin); m_lo += int'(LOin); m_zh += int'(Zin_high); m_rin |= reg_in;
            if (Yin && sb_q.size() > 0) chk("t3_reg_out", 64'(reg_out), 64'(sb_q[0].rout_t3));
            if ((|reg_out) && !Yin && sb_q.size() > 0) begin
                chk("t4_reg_out", 64'(reg_out), 64'(sb_q[0].rout_t4));
                chk("t4_operation", 64'(operation), 64'(sb_q[0].op));
            end
            if (done || err) begin
                if (sb_q.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL unexpected_end: done=%0b err=%0b with nothing expected", done, err);
                end else begin
                    e = sb_q.pop_front();
                    chk("end_kind", 64'({done, err}), e.is_err ? 64'd1 : 64'd2);
                    chk("latency", 64'(m_lat), 64'(e.lat));
                    chk("read_cycles", 64'(m_reads), 64'(e.reads));
                    chk("pcin_cycles", 64'(m_pcins), 64'(e.pcins));
                    chk("reg_in_seen", 64'(m_rin), 64'(e.rin_or));
                    chk("hi_lo_zh", 64'({m_hi, m_lo, m_zh}) , 64'({e.hi, e.lo, e.zh}));
                    chk("op_at_end", 64'(operation), 64'(e.op));
                end
                acc_reset();
            end
        end
    end

    task automatic run_instr(input logic [31:0] irv, input int w, input bit never, input bit poke);
        exp_t e;
        e = model(irv, w, never);
        sb_q.push_back(e);
        if (!e.is_err) model_op = e.op;
        ir = irv; start = 1'b1; mem_rdy = 1'b0;
        @(posedge clk); #1;
        for (int k = 1; k <= e.lat + 1; k++) begin
            start   = poke && (k == 3);
            mem_rdy = !never && (k == w + 2);
            @(posedge clk); #1;
        end
        start = 1'b0; mem_rdy = 1'b0;
        chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        chk("idle_after", 64'(busy), 64'd0);
        sb_q.delete();
    endtask

    task automatic clear_in_t4();
        ir = 32'h201A8000; start = 1'b1; mem_rdy = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            mem_rdy = (k == 2);
            @(posedge clk); #1;
        end
        mem_rdy = 1'b0;
        chk("clr_pre_t4", 64'({Zin_low, reg_out}), 64'({1'b1, 16'h0020}));
        clear = 1'b1;
        @(posedge clk); #1;
        chk("clr_outputs", 64'({strobes, operation}), 64'd0);
        clear = 1'b0; model_op = 4'd0;
        repeat (4) @(posedge clk);
        #1;
        chk("clr_stays_idle", 64'(busy), 64'd0);
    endtask

    initial begin
        logic [4:0] opc;
        int         sel;
        clear = 1'b1; start = 1'b0; mem_rdy = 1'b0; ir = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", 64'({strobes, operation}), 64'd0);
        clear = 1'b0;
        @(posedge clk); #1;
        run_instr(32'h201A8000, 0, 1'b0, 1'b0);
        run_instr(32'h19180000, 3, 1'b0, 1'b0);
        run_instr(32'h70090000, 0, 1'b0, 1'b1);
        run_instr(32'hF8000000, 0, 1'b0, 1'b0);
        run_instr(32'h201A8000, 0, 1'b1, 1'b0);
        clear_in_t4();
        run_instr(32'h19180000, 0, 1'b0, 1'b0);
        for (int n = 0; n < 40; n++) begin
            sel = $urandom_range(0, 9);
            if (sel <= 5)      opc = 5'($urandom_range(0, 11));
            else if (sel == 6) opc = 5'h0E;
            else if (sel == 7) opc = 5'h0F;
            else begin
                opc = 5'($urandom_range(0, 17));
                opc = (opc < 5'd2) ? 5'd12 + opc : 5'd14 + opc;
            end
            run_instr({opc, 27'($urandom)}, $urandom_range(0, 4), sel == 9, 1'($urandom_range(0, 1)));
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/microstep_sequencer.md
Name: microstep_sequencer

Overview:
- Synthesizable control unit that replaces the hand-timed control-signal sequences used in datapath benches.
- Steps the datapath through fetch (T0-T2) and execute (T3-T5/T6) for register-register ALU and HI/LO (mul/div) instructions.
- Drives one-hot register out/in strobes and the ALU operation code.
- Parametrised in data width, register count, operation width and memory timeout; adds a memory-ready handshake that fixed-delay sequencing lacks.

Parameters:
- DATA_WIDTH, 32, IR and data width.
- NUM_REGS, 16, general registers; field width REG_SEL_W = clog2(NUM_REGS), 4 by default.
- OP_WIDTH, 4, ALU operation code width.
- MEM_TIMEOUT, 15, max T1 cycles waiting for mem_rdy.

Ports:
- Clock in 1: sole clock, rising edge.
- clear in 1: synchronous, active-high reset.
- start in 1: begin one instruction; sampled in IDLE only.
- mem_rdy in 1: memory read data valid during T1.
- ir in DATA_WIDTH: IR register contents.
- busy out 1: high from T0 through the final step.
- done out 1: one-cycle pulse in the final step.
- err out 1: one-cycle pulse on illegal opcode or timeout.
- PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin, Yin out 1 each: datapath strobes.
- Zin_low, Zin_high, Zlowout, Zhighout, HIin, LOin out 1 each: Z/HI/LO strobes.
- reg_out out NUM_REGS: one-hot register-to-bus enable.
- reg_in out NUM_REGS: one-hot bus-to-register enable.
- operation out OP_WIDTH: ALU operation select.

Behaviour:
- IR fields: opcode ir[31:27]; Ra ir[26:23]; Rb ir[22:19]; Rc ir[18:15]. Fields are REG_SEL_W wide, with the top fields kept at fixed positions.
- Opcode classes:
  - 0x00-0x0B are ALU ops; operation = opcode[OP_WIDTH-1:0].
  - 0x0E is mul and 0x0F is div; both are HI/LO class.
  - All other opcodes are illegal.
- Moore outputs, decoded from the registered state. Every output is 0 in IDLE and after clear.
- States and strobes:
  - IDLE: start=1 -> T0 next edge.
  - T0: PCout, MARin, IncPC, Zin_low -> T1.
  - T1: Zlowout, PCin, Read, MDRin; PCin/Zlowout asserted only in the first T1 cycle; Read/MDRin held until mem_rdy=1. Exits -> T2 at the mem_rdy edge; timeout -> err, IDLE.
  - T2: MDRout, IRin -> T3.
  - T3: ir decoded combinationally. Illegal opcode: err pulse, no strobes, -> IDLE. Otherwise reg_out[Rb], Yin; latch opcode, Ra and Rc internally -> T4.
  - T4: reg_out[Rc], operation, Zin_low; HI/LO class also asserts Zin_high -> T5.
  - T5: ALU class asserts Zlowout, reg_in[Ra], done -> IDLE. HI/LO class asserts Zlowout, LOin -> T6.
  - T6: Zhighout, HIin, done -> IDLE.
- Latency: start to done is 6 cycles (ALU) or 7 (HI/LO) with mem_rdy high in the first T1 cycle. Each extra wait cycle adds 1.
- Timeout counter: cleared on T1 entry. If mem_rdy has not been seen after MEM_TIMEOUT cycles in T1, assert err and return to IDLE.
- operation holds its last value outside T4 and is 0 after reset.
- start while busy is ignored.
- clear mid-instruction: IDLE and all outputs 0 at the next edge, with no done or err.
- Simultaneous start and clear: clear wins.
- reg_out and reg_in are never both nonzero in the same cycle.

Optional Feature:
- Macro: MICROSTEP_SINGLE_STEP_EN.
- Defined: adds input step_req (1 bit). Every non-IDLE state holds, with outputs asserted, until step_req=1. T1 additionally still needs mem_rdy. The timeout counter is frozen while waiting for step_req.
- Undefined: no port; states advance every cycle as above.

Decomposition:
- Package microstep_pkg holds:
  - state encoding localparams (IDLE, T0-T6);
  - opcode class constants (ALU range bounds, OPC_MUL=5'h0E, OPC_DIV=5'h0F);
  - IR field bit positions.
- One sub-module, onehot_decoder (parametrised N, index -> N-bit one-hot with enable), instantiated for reg_out and reg_in.

Test Plan:
- clear=1 for 2 cycles -> every output 0, busy=0; then start with ir=0x201A8000 (shl, Ra=0, Rb=3, Rc=5) and mem_rdy=1 -> expected strobes:
  - T3: reg_out=16'h0008.
  - T4: reg_out=16'h0020, operation=4'b0100.
  - T5: reg_in=16'h0001 with done; busy for exactly 6 cycles.
- ir=0x19180000 (opcode 3, Ra=2, Rb=3), mem_rdy low for 3 T1 cycles -> Read held 4 cycles, PCin 1 cycle, done 9 cycles after start, reg_in=16'h0004.
- ir=0x70090000 (mul, Rb=1, Rc=2) -> T4 asserts Zin_low and Zin_high; T5 LOin; T6 HIin plus done; reg_in stays 0 throughout.
- Opcode 0x1F -> err pulse in T3, back to IDLE, no done, no reg_in; mem_rdy never asserted -> err after 15 T1 cycles.
- clear asserted in T4 -> next cycle all outputs 0 and IDLE; start pulsed during busy -> ignored, single done only.
